// File: rtl/bnn_instr_encoder.sv
// Expands one BNN layer command into a BNNCMS / N x BCNV / BNN sequence of
// custom-opcode instruction words, streamed out over a valid/ready port.
module bnn_instr_encoder #(
    parameter int unsigned COUNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [11:0]        cmd_size,
    input  logic [4:0]         cmd_rs1,
    input  logic [4:0]         cmd_rs2,
    input  logic [4:0]         cmd_rd,
    input  logic [COUNT_W-1:0] cmd_count,
    input  logic [11:0]        cmd_thresh,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [31:0]        instr_word,
    output logic               busy,
    output logic               done
);

    localparam logic [6:0] OPCODE = 7'h7F;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMS,
        S_CNV,
        S_BNN,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [11:0]        size_r;
    logic [11:0]        thr_r;
    logic [4:0]         rs1_r;
    logic [4:0]         rs2_r;
    logic [4:0]         rd_r;
    logic [COUNT_W-1:0] count_r;
    logic [COUNT_W-1:0] idx;
    logic [4:0]         rs1_i;
    logic [4:0]         rs2_i;
    logic               instr_fire;
    logic               cnv_last;

    // Register stepping wraps 31 -> 1 so x0 is never produced by stepping.
    function automatic logic [4:0] step_reg(input logic [4:0] r);
        return (r == 5'd31) ? 5'd1 : r + 5'd1;
    endfunction

    function automatic logic [31:0] cms_word(input logic [11:0] sz, input logic [4:0] rs1,
                                             input logic [4:0] rd);
        return {sz, rs1, 3'b000, rd, OPCODE};
    endfunction

    function automatic logic [31:0] cnv_word(input logic [4:0] rs1, input logic [4:0] rs2,
                                             input logic [4:0] rd);
        return {7'b0, rs2, rs1, 3'b001, rd, OPCODE};
    endfunction

    function automatic logic [31:0] bnn_word(input logic [11:0] thr, input logic [4:0] rs1,
                                             input logic [4:0] rs2);
        return {thr[11:5], rs2, rs1, 3'b010, thr[4:0], OPCODE};
    endfunction

    assign instr_fire = instr_valid && instr_ready;
    assign cnv_last   = (idx == count_r - COUNT_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        cmd_ready   = 1'b0;
        instr_valid = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) state_nx = S_CMS;
            end
            S_CMS: begin
                instr_valid = 1'b1;
                if (instr_ready) state_nx = (count_r != '0) ? S_CNV : S_BNN;
            end
            S_CNV: begin
                instr_valid = 1'b1;
                if (instr_ready && cnv_last) state_nx = S_BNN;
            end
            S_BNN: begin
                instr_valid = 1'b1;
                if (instr_ready) state_nx = S_DONE;
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // The next word is loaded on the handshake of the current one, so
    // instr_word is already stable when the following state presents it.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_word <= '0;
            size_r     <= '0;
            thr_r      <= '0;
            rs1_r      <= '0;
            rs2_r      <= '0;
            rd_r       <= '0;
            count_r    <= '0;
            idx        <= '0;
            rs1_i      <= '0;
            rs2_i      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        size_r     <= cmd_size;
                        thr_r      <= cmd_thresh;
                        rs1_r      <= cmd_rs1;
                        rs2_r      <= cmd_rs2;
                        rd_r       <= cmd_rd;
                        count_r    <= cmd_count;
                        idx        <= '0;
                        instr_word <= cms_word(cmd_size, cmd_rs1, cmd_rd);
                    end
                end
                S_CMS: begin
                    if (instr_fire) begin
                        if (count_r != '0) begin
                            instr_word <= cnv_word(rs1_r, rs2_r, rd_r);
                            rs1_i      <= step_reg(rs1_r);
                            rs2_i      <= step_reg(rs2_r);
                        end else begin
                            instr_word <= bnn_word(thr_r, rs1_r, rs2_r);
                        end
                    end
                end
                S_CNV: begin
                    if (instr_fire) begin
                        if (cnv_last) begin
                            instr_word <= bnn_word(thr_r, rs1_r, rs2_r);
                        end else begin
                            instr_word <= cnv_word(rs1_i, rs2_i, rd_r);
                            rs1_i      <= step_reg(rs1_i);
                            rs2_i      <= step_reg(rs2_i);
                            idx        <= idx + COUNT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bnn_instr_encoder.sv
// Scoreboard bench for bnn_instr_encoder: a reference model queues the expected
// word stream per command, and a monitor pops and compares on every handshake.
module tb_bnn_instr_encoder;

    localparam int unsigned COUNT_W = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [11:0]        cmd_size;
    logic [4:0]         cmd_rs1;
    logic [4:0]         cmd_rs2;
    logic [4:0]         cmd_rd;
    logic [COUNT_W-1:0] cmd_count;
    logic [11:0]        cmd_thresh;
    logic               instr_valid;
    logic               instr_ready;
    logic [31:0]        instr_word;
    logic               busy;
    logic               done;

    bnn_instr_encoder #(.COUNT_W(COUNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_size   (cmd_size),
        .cmd_rs1    (cmd_rs1),
        .cmd_rs2    (cmd_rs2),
        .cmd_rd     (cmd_rd),
        .cmd_count  (cmd_count),
        .cmd_thresh (cmd_thresh),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr_word (instr_word),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] w;
        bit          last;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    bit          rand_rdy = 1'b0;
    bit          expect_done;
    bit          prev_stall;
    logic [31:0] prev_word;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // Register field at BCNV index i, from the stepping rule in closed form.
    function automatic logic [4:0] model_rs(input int base, input int i);
        int start;
        int k;
        if (base == 0 && i == 0) return 5'd0;
        start = (base == 0) ? 1 : base;
        k     = (base == 0) ? i - 1 : i;
        return 5'(((start - 1 + k) % 31) + 1);
    endfunction

    task automatic model_push(input logic [11:0] sz, input logic [4:0] a, input logic [4:0] b,
                              input logic [4:0] d, input logic [7:0] cnt, input logic [11:0] th);
        exp_t e;
        e.last = 1'b0;
        e.w = (32'(sz) << 20) | (32'(a) << 15) | (32'(d) << 7) | 32'h7F;
        q.push_back(e);
        for (int i = 0; i < int'(cnt); i++) begin
            e.w = (32'(model_rs(int'(b), i)) << 20) | (32'(model_rs(int'(a), i)) << 15)
                | (32'd1 << 12) | (32'(d) << 7) | 32'h7F;
            q.push_back(e);
        end
        e.w = (32'(th >> 5) << 25) | (32'(b) << 20) | (32'(a) << 15) | (32'd2 << 12)
            | (32'(th & 12'h1F) << 7) | 32'h7F;
        e.last = 1'b1;
        q.push_back(e);
    endtask

    // Monitor: pops the scoreboard on each handshake, checks done timing and stall hold.
    initial begin
        expect_done = 1'b0;
        prev_stall  = 1'b0;
        prev_word   = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                expect_done = 1'b0;
                prev_stall  = 1'b0;
            end else begin
                if (done || expect_done) check("done_pulse", 32'(done), 32'(expect_done));
                expect_done = 1'b0;
                if (prev_stall) begin
                    check("stall_valid", 32'(instr_valid), 32'd1);
                    check("stall_word", instr_word, prev_word);
                end
                if (instr_valid && instr_ready) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_word: got 0x%08h expected no word", instr_word);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        check("word", instr_word, e.w);
                        expect_done = e.last;
                    end
                end
                prev_stall = instr_valid && !instr_ready;
                prev_word  = instr_word;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) instr_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send_cmd(input logic [11:0] sz, input logic [4:0] a, input logic [4:0] b,
                            input logic [4:0] d, input logic [7:0] cnt, input logic [11:0] th,
                            input bit hold_valid);
        int n;
        bit ok;
        cmd_size   = sz;
        cmd_rs1    = a;
        cmd_rs2    = b;
        cmd_rd     = d;
        cmd_count  = cnt;
        cmd_thresh = th;
        cmd_valid  = 1'b1;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 100) begin
            @(negedge clk);
            n++;
            if (cmd_ready) begin
                model_push(sz, a, b, d, cnt, th);
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) check("cmd_accept_timeout", 32'(n), 32'd0);
        if (!hold_valid) cmd_valid = 1'b0;
    endtask

    // Waits for done; optionally checks latency and that cmd_ready stays low
    // while the command fields are scrambled underneath a busy encoder.
    task automatic wait_done(input int cnt, input int exp_lat, input bit garbage);
        int n;
        int budget;
        n      = 0;
        budget = 20 * (cnt + 4) + 100;
        forever begin
            @(negedge clk);
            n++;
            if (done) break;
            if (garbage) check("cmd_ready_busy", 32'(cmd_ready), 32'd0);
            if (n > budget) begin
                check("done_timeout", 32'(n), 32'(budget));
                break;
            end
            if (garbage) begin
                @(posedge clk);
                #1;
                cmd_size   = 12'($urandom);
                cmd_rs1    = 5'($urandom);
                cmd_rs2    = 5'($urandom);
                cmd_rd     = 5'($urandom);
                cmd_count  = 8'($urandom);
                cmd_thresh = 12'($urandom);
            end
        end
        if (exp_lat >= 0) check("done_latency", 32'(n), 32'(exp_lat));
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("drain", 32'(q.size()), 32'd0);
    endtask

    initial begin
        reset       = 1'b1;
        cmd_valid   = 1'b0;
        instr_ready = 1'b1;
        cmd_size    = '0;
        cmd_rs1     = '0;
        cmd_rs2     = '0;
        cmd_rd      = '0;
        cmd_count   = '0;
        cmd_thresh  = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_word", instr_word, 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;

        send_cmd(12'd9, 5'd5, 5'd6, 5'd3, 8'd1, 12'h025, 1'b0);
        wait_done(1, 4, 1'b0);
        send_cmd(12'd9, 5'd5, 5'd6, 5'd3, 8'd0, 12'h025, 1'b0);
        wait_done(0, 3, 1'b0);
        send_cmd(12'd9, 5'd31, 5'd30, 5'd3, 8'd3, 12'hABC, 1'b0);
        wait_done(3, 6, 1'b0);
        send_cmd(12'hFFF, 5'd0, 5'd0, 5'd0, 8'd4, 12'hFFF, 1'b0);
        wait_done(4, 7, 1'b0);

        send_cmd(12'h123, 5'd7, 5'd8, 5'd9, 8'd2, 12'h3C1, 1'b0);
        @(posedge clk);
        #1;
        instr_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        instr_ready = 1'b1;
        wait_done(2, -1, 1'b0);

        send_cmd(12'h055, 5'd29, 5'd1, 5'd4, 8'd10, 12'h010, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("midrst_valid", 32'(instr_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("midrst_done", 32'(done), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        send_cmd(12'd9, 5'd5, 5'd6, 5'd3, 8'd1, 12'h025, 1'b0);
        wait_done(1, 4, 1'b0);

        send_cmd(12'h7A5, 5'd17, 5'd31, 5'd12, 8'd255, 12'h5A5, 1'b1);
        wait_done(255, 258, 1'b1);

        rand_rdy = 1'b1;
        for (int c = 0; c < 12; c++) begin
            logic [7:0] cnt;
            cnt = 8'($urandom_range(0, 12));
            send_cmd(12'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), cnt,
                     12'($urandom), 1'b0);
            wait_done(int'(cnt), -1, 1'b0);
        end
        rand_rdy = 1'b0;
        @(posedge clk);
        #2;
        instr_ready = 1'b1;
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
